// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: opcodes, sequencer stage codes and flag bit positions.
package calc_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'b001;
    localparam logic [2:0] ALU_OP_SUB = 3'b010;
    localparam logic [2:0] ALU_OP_MUL = 3'b011;
    localparam logic [2:0] ALU_OP_AND = 3'b100;
    localparam logic [2:0] ALU_OP_OR  = 3'b101;

    localparam logic [2:0] S_OP1  = 3'd0;
    localparam logic [2:0] S_OP2  = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic op_supported(input logic [2:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) || (op == ALU_OP_MUL) ||
               (op == ALU_OP_AND) || (op == ALU_OP_OR);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational two's-complement ALU: add/sub/mul/and/or with {N,Z,C,V} flags.
module alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic               carry;
    logic               ovf;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;
    // Sign-extended unsigned multiply gives the exact signed product in 2*WIDTH bits.
    assign prod    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ALU_OP_ADD: begin
                y     = sum_ext[WIDTH-1:0];
                carry = sum_ext[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                y   = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OP_MUL: begin
                y   = prod[WIDTH-1:0];
                ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
            end
            ALU_OP_AND: y = a & b;
            ALU_OP_OR:  y = a | b;
            default:    y = '0;
        endcase
    end

    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = y[WIDTH-1];
        flags[FLAG_Z] = (y == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Calculator command sequencer: latches operands and opcode on enter strobes, runs one ALU
// cycle and holds the registered result/flags for display.
module alu_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enter,
    input  logic             clear,
    output logic [WIDTH-1:0] in1_q,
    output logic [WIDTH-1:0] in2_q,
    output logic [2:0]       op_q,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [2:0]       stage,
    output logic             result_valid,
    output logic             op_error
);

    logic [2:0]       state_reg;
    logic [WIDTH-1:0] alu_y;
    logic [3:0]       alu_flags;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a     (in1_q),
        .b     (in2_q),
        .op    (op_q),
        .y     (alu_y),
        .flags (alu_flags)
    );

    assign stage = state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_OP1;
            in1_q        <= '0;
            in2_q        <= '0;
            op_q         <= 3'b000;
            result       <= '0;
            flags        <= 4'b0000;
            result_valid <= 1'b0;
            op_error     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            op_error     <= 1'b0;
            // clear overrides everything, including a same-cycle enter and an S_EXEC update.
            if (clear) begin
                state_reg <= S_OP1;
            end else begin
                case (state_reg)
                    S_OP1: if (enter) begin
                        in1_q     <= data_in;
                        state_reg <= S_OP2;
                    end
                    S_OP2: if (enter) begin
                        in2_q     <= data_in;
                        state_reg <= S_OP;
                    end
                    S_OP: if (enter) begin
                        if (op_supported(data_in[2:0])) begin
                            op_q      <= data_in[2:0];
                            state_reg <= S_EXEC;
                        end else begin
                            op_error  <= 1'b1;
                        end
                    end
                    S_EXEC: begin
                        result       <= alu_y;
                        flags        <= alu_flags;
                        result_valid <= 1'b1;
                        state_reg    <= S_SHOW;
                    end
                    S_SHOW: if (enter) begin
                        // Chain: the displayed result becomes the next first operand.
                        in1_q     <= result;
                        state_reg <= S_OP2;
                    end
                    default: state_reg <= S_OP1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer against an integer-arithmetic reference.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] in1_q, in2_q, result;
    logic [2:0]  op_q, stage;
    logic [3:0]  flags;
    logic        result_valid, op_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_in1, exp_in2, exp_res;
    logic [2:0]  exp_op;
    logic [3:0]  exp_flags;

    alu_sequencer #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .enter        (enter),
        .clear        (clear),
        .in1_q        (in1_q),
        .in2_q        (in2_q),
        .op_q         (op_q),
        .result       (result),
        .flags        (flags),
        .stage        (stage),
        .result_valid (result_valid),
        .op_error     (op_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic, returns {N,Z,C,V, result}.
    function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s  = 0;
        logic   c  = 1'b0;
        logic   v  = 1'b0;
        logic [15:0] r;
        case (op)
            3'd1: begin s = sa + sb; c = (ua + ub) > 65535; end
            3'd2: s = sa - sb;
            3'd3: s = sa * sb;
            3'd4: s = longint'(a & b);
            3'd5: s = longint'(a | b);
            default: s = 0;
        endcase
        r = 16'(s);
        if (op inside {3'd1, 3'd2, 3'd3}) v = (s > 32767) || (s < -32768);
        return {r[15], r == 16'd0, c, v, r};
    endfunction

    task automatic press(input logic [15:0] v);
        data_in = v;
        enter   = 1'b1;
        @(posedge clk); #1;
        enter   = 1'b0;
        data_in = 16'($urandom);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_eq("clear_stage", 32'(stage), 32'd0);
    endtask

    task automatic load_operands(input logic [15:0] a, input logic [15:0] b);
        press(a);
        exp_in1 = a;
        check_eq("op1_stage", 32'(stage), 32'd1);
        check_eq("op1_in1", 32'(in1_q), 32'(exp_in1));
        press(b);
        exp_in2 = b;
        check_eq("op2_stage", 32'(stage), 32'd2);
        check_eq("op2_in2", 32'(in2_q), 32'(exp_in2));
    endtask

    // Starts in S_OP with a supported opcode; checks S_EXEC, the result pulse and the hold.
    task automatic exec_op(input logic [2:0] op);
        logic [19:0] m;
        m = ref_alu(exp_in1, exp_in2, op);
        press({13'($urandom), op});
        exp_op = op;
        check_eq("exec_stage", 32'(stage), 32'd3);
        check_eq("exec_op_q", 32'(op_q), 32'(op));
        check_eq("exec_rv_low", 32'(result_valid), 32'd0);
        idle_cycle();
        exp_res   = m[15:0];
        exp_flags = m[19:16];
        check_eq("show_stage", 32'(stage), 32'd4);
        check_eq("show_result", 32'(result), 32'(exp_res));
        check_eq("show_flags", 32'(flags), 32'(exp_flags));
        check_eq("show_rv", 32'(result_valid), 32'd1);
        idle_cycle();
        check_eq("show_rv_once", 32'(result_valid), 32'd0);
        check_eq("show_hold", 32'(result), 32'(exp_res));
        $display("calc %h op%0d %h -> result %h flags %b", exp_in1, op, exp_in2, result, flags);
    endtask

    task automatic do_calc(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        load_operands(a, b);
        exec_op(op);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stage", 32'(stage), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_in1", 32'(in1_q), 32'd0);
        reset = 1'b0;
        idle_cycle();

        do_calc(16'd5, 16'd3, 3'b001);
        check_eq("add_5_3", 32'(result), 32'd8);
        check_eq("add_flags", 32'(flags), 32'b0000);
        do_clear();
        do_calc(16'd3, 16'd5, 3'b010);
        check_eq("sub_neg", 32'(result), 32'hFFFE);
        check_eq("sub_neg_flags", 32'(flags), 32'b1000);
        do_clear();
        do_calc(16'd7, 16'd7, 3'b010);
        check_eq("sub_zero_flags", 32'(flags), 32'b0100);
        do_clear();
        do_calc(16'h7FFF, 16'd1, 3'b001);
        check_eq("add_ovf", 32'(result), 32'h8000);
        check_eq("add_ovf_flags", 32'(flags), 32'b1001);
        do_clear();
        do_calc(16'd300, 16'd300, 3'b011);
        check_eq("mul_trunc", 32'(result), 32'h5F90);
        check_eq("mul_flags", 32'(flags), 32'b0001);
        do_clear();

        // Unsupported opcode: pulse, no state change, then a valid one proceeds.
        load_operands(16'h00F0, 16'h0F3C);
        press(16'h0006);
        check_eq("bad_op_err", 32'(op_error), 32'd1);
        check_eq("bad_op_stage", 32'(stage), 32'd2);
        check_eq("bad_op_q", 32'(op_q), 32'(exp_op));
        idle_cycle();
        check_eq("bad_op_err_once", 32'(op_error), 32'd0);
        exec_op(3'b100);
        do_clear();

        // Chain from S_SHOW: result becomes operand 1, data_in ignored.
        do_calc(16'd5, 16'd3, 3'b001);
        press(16'hDEAD);
        exp_in1 = 16'd8;
        check_eq("chain_stage", 32'(stage), 32'd1);
        check_eq("chain_in1", 32'(in1_q), 32'd8);
        press(16'd2);
        exp_in2 = 16'd2;
        exec_op(3'b011);
        check_eq("chain_mul", 32'(result), 32'd16);

        // clear and enter together: clear wins.
        do_clear();
        press(16'd9);
        exp_in1 = 16'd9;
        clear = 1'b1; enter = 1'b1; data_in = 16'd77;
        idle_cycle();
        clear = 1'b0; enter = 1'b0;
        check_eq("ce_stage", 32'(stage), 32'd0);
        check_eq("ce_in1", 32'(in1_q), 32'(exp_in1));
        check_eq("ce_in2", 32'(in2_q), 32'(exp_in2));
        check_eq("ce_op", 32'(op_q), 32'(exp_op));

        // clear during S_EXEC: no update, no pulse.
        load_operands(16'd100, 16'd1);
        press(16'h0001);
        check_eq("abort_exec_stage", 32'(stage), 32'd3);
        clear = 1'b1;
        idle_cycle();
        clear = 1'b0;
        check_eq("abort_stage", 32'(stage), 32'd0);
        check_eq("abort_result", 32'(result), 32'(exp_res));
        check_eq("abort_flags", 32'(flags), 32'(exp_flags));
        check_eq("abort_rv", 32'(result_valid), 32'd0);
        idle_cycle();
        check_eq("abort_rv_late", 32'(result_valid), 32'd0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            do_calc(16'($urandom), 16'($urandom), 3'($urandom_range(1, 5)));
            if ($urandom_range(0, 1) == 1) begin
                press(16'($urandom));
                exp_in1 = exp_res;
                check_eq("rand_chain_in1", 32'(in1_q), 32'(exp_in1));
                press(16'($urandom_range(0, 65535)));
                exp_in2 = data_in;
                exp_in2 = in2_q;
                check_eq("rand_chain_stage", 32'(stage), 32'd2);
                exec_op(3'($urandom_range(1, 5)));
            end
            do_clear();
        end

        // Asynchronous reset in the middle of S_EXEC.
        load_operands(16'h1234, 16'h4321);
        press(16'h0001);
        check_eq("rst_exec_stage", 32'(stage), 32'd3);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_stage", 32'(stage), 32'd0);
        check_eq("arst_in1", 32'(in1_q), 32'd0);
        check_eq("arst_in2", 32'(in2_q), 32'd0);
        check_eq("arst_op", 32'(op_q), 32'd0);
        check_eq("arst_result", 32'(result), 32'd0);
        check_eq("arst_flags", 32'(flags), 32'd0);
        check_eq("arst_rv", 32'(result_valid), 32'd0);
        idle_cycle();
        reset = 1'b0;
        idle_cycle();
        check_eq("arst_after_stage", 32'(stage), 32'd0);
        check_eq("arst_after_result", 32'(result), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
